// File: rtl/tank_pkg.sv
// Shared definitions for the water-tank plant emulator and its controller.
// Holds the plant FSM encoding, LFSR taps, default sensor thresholds and the feedback helper.
package tank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } plant_state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned LOW_THR_D  = 32'd31;
  localparam int unsigned HIGH_THR_D = 32'd255;

  function automatic logic lfsr_fb(input logic [15:0] st);
    return ^(st & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/tank_lfsr16.sv
// 16-bit Fibonacci LFSR shifting left with feedback into bit 0.
// Exposes the current state and the value it would take on the next advance.
module tank_lfsr16
  import tank_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] lfsr,
  output logic [15:0] lfsr_nxt
);

  logic [15:0] state_r;
  logic [15:0] nxt_s;

  assign nxt_s    = {state_r[14:0], lfsr_fb(state_r)};
  assign lfsr     = state_r;
  assign lfsr_nxt = nxt_s;

  // State register; an all-zero state (only reachable by an upset) reseeds itself
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= SEED;
    end else if (state_r == 16'h0000) begin
      state_r <= SEED;
    end else if (adv) begin
      state_r <= nxt_s;
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/tank_plant_emu.sv
// Water-tank plant emulator: integrates a pseudo-random level change per step
// according to the pump command and drives the low/high level sensors.
module tank_plant_emu
  import tank_pkg::*;
#(
  parameter int unsigned         LEVEL_W       = 32'd16,
  parameter logic [LEVEL_W-1:0]  INIT_LEVEL    = LEVEL_W'(32'd100),
  parameter logic [LEVEL_W-1:0]  LOW_THR       = LEVEL_W'(LOW_THR_D),
  parameter logic [LEVEL_W-1:0]  HIGH_THR      = LEVEL_W'(HIGH_THR_D),
  parameter logic [15:0]         LFSR_SEED     = 16'hACE1,
  parameter bit                  HALT_ON_FAULT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               s,
  input  logic               load,
  input  logic [LEVEL_W-1:0] load_val,
  input  logic               clr_flags,
  output logic               a,
  output logic               b,
  output logic [LEVEL_W-1:0] level,
  output logic [3:0]         incr,
  output logic               ovf,
  output logic               udf,
  output logic               halted
);

  plant_state_t        state_r, state_n;
  logic [LEVEL_W-1:0]  level_r, level_n;
  logic [3:0]          incr_r, incr_n;
  logic                ovf_r, ovf_n;
  logic                udf_r, udf_n;

  logic [15:0]         lfsr_s, lfsr_nxt_s;
  logic                lfsr_live_s;
  logic                step_s;
  logic [3:0]          r_s, m_s;
  logic [LEVEL_W-1:0]  m_ext_s;
  logic [LEVEL_W:0]    sum_s;
  logic                add_clip_s, sub_clip_s;
  logic                ovf_set_s, udf_set_s, halt_req_s;

  tank_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .adv      (step_s),
    .lfsr     (lfsr_s),
    .lfsr_nxt (lfsr_nxt_s)
  );

  // A healthy LFSR never maps to itself; a stuck one skips the step while it reseeds
  assign lfsr_live_s = (lfsr_nxt_s != lfsr_s);
  assign step_s      = en & ~load & (state_r != HALT) & lfsr_live_s;

  assign r_s        = lfsr_nxt_s[3:0];
  assign m_s        = (r_s == 4'hF) ? 4'h0 : r_s;
  assign m_ext_s    = LEVEL_W'(m_s);
  assign sum_s      = {1'b0, level_r} + (LEVEL_W + 1)'(m_s);
  assign add_clip_s = sum_s[LEVEL_W];
  assign sub_clip_s = (m_ext_s > level_r);

  assign ovf_set_s  = step_s & s & add_clip_s;
  assign udf_set_s  = step_s & ~s & sub_clip_s;
  assign halt_req_s = HALT_ON_FAULT & (ovf_set_s | udf_set_s);

  // Level, magnitude and sticky flag next-state; load outranks a step
  always_comb begin
    level_n = level_r;
    incr_n  = incr_r;
    if (load) begin
      level_n = load_val;
      incr_n  = 4'h0;
    end else if (step_s) begin
      incr_n = m_s;
      if (s) begin
        if (add_clip_s) begin
          level_n = {LEVEL_W{1'b1}};
        end else begin
          level_n = sum_s[LEVEL_W-1:0];
        end
      end else begin
        if (sub_clip_s) begin
          level_n = {LEVEL_W{1'b0}};
        end else begin
          level_n = level_r - m_ext_s;
        end
      end
    end else begin
      level_n = level_r;
    end

    if (clr_flags) begin
      ovf_n = ovf_set_s;
      udf_n = udf_set_s;
    end else begin
      ovf_n = ovf_r | ovf_set_s;
      udf_n = udf_r | udf_set_s;
    end
  end

  // Plant FSM next-state
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (step_s) begin
          state_n = halt_req_s ? HALT : RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (step_s && halt_req_s) begin
          state_n = HALT;
        end else begin
          state_n = RUN;
        end
      end
      HALT: begin
        if (clr_flags) begin
          state_n = RUN;
        end else begin
          state_n = HALT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_r <= INIT_LEVEL;
      incr_r  <= 4'h0;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      level_r <= level_n;
      incr_r  <= incr_n;
      ovf_r   <= ovf_n;
      udf_r   <= udf_n;
    end
  end

  assign a      = (level_r > LOW_THR);
  assign b      = (level_r > HIGH_THR);
  assign level  = level_r;
  assign incr   = incr_r;
  assign ovf    = ovf_r;
  assign udf    = udf_r;
  assign halted = (state_r == HALT);

endmodule

// File: tb/tb_tank_plant_emu.sv
// Directed bench for tank_plant_emu: a spec-level reference model plus hand-computed
// checkpoints derived from the LFSR sequence starting at 16'hACE1 (m = 3,7,0,14,12,9,2,4,8,1).
module tb_tank_plant_emu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        s = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic        clr_flags = 1'b0;
  logic        a, b, ovf, udf, halted;
  logic [15:0] level;
  logic [3:0]  incr;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  logic [15:0] m_level;
  logic [3:0]  m_incr;
  logic        m_ovf, m_udf;
  int          m_state;
  logic        ctrl_s;

  tank_plant_emu dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .s         (s),
    .load      (load),
    .load_val  (load_val),
    .clr_flags (clr_flags),
    .a         (a),
    .b         (b),
    .level     (level),
    .incr      (incr),
    .ovf       (ovf),
    .udf       (udf),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic model_reset();
    m_lfsr  = 16'hACE1;
    m_level = 16'd100;
    m_incr  = 4'h0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_state = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_level"}, level, m_level);
    chk({tag, "_incr"}, incr, m_incr);
    chk({tag, "_a"}, a, m_level > 16'd31);
    chk({tag, "_b"}, b, m_level > 16'd255);
    chk({tag, "_ovf"}, ovf, m_ovf);
    chk({tag, "_udf"}, udf, m_udf);
    chk({tag, "_halted"}, halted, m_state == 2);
  endtask

  // Apply one cycle of inputs, advance the reference model, then sample after the edge.
  task automatic cycle(input string tag, input logic en_i, input logic s_i, input logic load_i,
                       input logic [15:0] lv, input logic clr_i);
    logic [3:0]  mm;
    logic [16:0] sum;
    logic        clip_o, clip_u, stepping;
    en = en_i; s = s_i; load = load_i; load_val = lv; clr_flags = clr_i;
    clip_o = 1'b0;
    clip_u = 1'b0;
    stepping = en_i && !load_i && (m_state != 2);
    if (load_i) begin
      m_level = lv;
      m_incr  = 4'h0;
    end else if (stepping) begin
      m_lfsr = ref_lfsr(m_lfsr);
      mm = (m_lfsr[3:0] == 4'hF) ? 4'h0 : m_lfsr[3:0];
      if (s_i) begin
        sum = {1'b0, m_level} + {13'b0, mm};
        if (sum[16]) begin m_level = 16'hFFFF; clip_o = 1'b1; end
        else m_level = sum[15:0];
      end else begin
        if ({12'b0, mm} > m_level) begin m_level = 16'h0000; clip_u = 1'b1; end
        else m_level = m_level - {12'b0, mm};
      end
      m_incr = mm;
    end
    if (clr_i) begin m_ovf = clip_o; m_udf = clip_u; end
    else begin m_ovf = m_ovf | clip_o; m_udf = m_udf | clip_u; end
    if (m_state == 2) begin
      if (clr_i) m_state = 1;
    end else if (stepping) begin
      m_state = (clip_o || clip_u) ? 2 : 1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset asserted from time zero
    model_reset();
    #12;
    check_all("rst_hold");
    chk("rst_a_const", a, 1'b1);
    chk("rst_b_const", b, 1'b0);
    rst = 1'b1;

    // Idle with en=0: nothing moves
    for (int i = 0; i < 10; i++) cycle("idle", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("idle_level_const", level, 16'd100);

    // Fill from 250: 253, 260, 260 (m=0), 274, 286, 295
    cycle("load250", 1'b0, 1'b0, 1'b1, 16'd250, 1'b0);
    cycle("fill1", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("fill1_const", level, 16'd253);
    chk("fill1_b_low", b, 1'b0);
    cycle("fill2", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("fill2_const", level, 16'd260);
    chk("fill2_b_high", b, 1'b1);
    cycle("fill3", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("fill3_m0_incr", incr, 4'd0);
    for (int i = 0; i < 3; i++) cycle("fill", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("fill6_const", level, 16'd295);

    // Drain from 5: 3 (m=2), then m=4 underflows to 0 and halts
    cycle("load5", 1'b1, 1'b0, 1'b1, 16'd5, 1'b0);
    for (int i = 0; i < 10 && m_state != 2; i++) cycle("drain", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("udf_level_const", level, 16'd0);
    chk("udf_flag_const", udf, 1'b1);
    chk("udf_halt_const", halted, 1'b1);
    for (int i = 0; i < 3; i++) cycle("halt_hold", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle("clr_udf", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("clr_udf_const", udf, 1'b0);

    // Overflow from FFFA: m=8 only if the LFSR held during HALT
    cycle("loadFFFA", 1'b1, 1'b1, 1'b1, 16'hFFFA, 1'b0);
    cycle("ovf_step", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("ovf_level_const", level, 16'hFFFF);
    chk("ovf_incr_const", incr, 4'd8);
    chk("ovf_halt_const", halted, 1'b1);
    cycle("clr_ovf", 1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
    chk("clr_ovf_const", ovf, 1'b0);
    cycle("clr_and_clip", 1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
    chk("clr_clip_ovf_const", ovf, 1'b1);
    chk("clr_clip_halt_const", halted, 1'b1);
    chk("clr_clip_incr_const", incr, 4'd1);

    // Async reset mid-cycle while running at 300
    cycle("clr_run", 1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
    cycle("load300", 1'b1, 1'b1, 1'b1, 16'd300, 1'b0);
    en = 1'b0; load = 1'b0; clr_flags = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_level_const", level, 16'd100);
    @(posedge clk);
    #1;
    check_all("rst_edge");
    #4;
    rst = 1'b1;
    cycle("rerun1", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("rerun1_const", level, 16'd103);
    cycle("rerun2", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("rerun2_const", level, 16'd110);
    cycle("rerun3", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    cycle("rerun4", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("rerun4_const", level, 16'd124);

    // Closed loop against a hysteresis controller driven from the sensors
    ctrl_s = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cycle("loop", 1'b1, ctrl_s, 1'b0, 16'h0, 1'b0);
      chk("loop_range", (level >= 16'd17) && (level <= 16'd269), 1'b1);
      if (!a) ctrl_s = 1'b1;
      else if (b) ctrl_s = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
